pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Downstream measurement stage for the PWM generator. It samples a pulse train (normally the generator's pwm_out) and measures high time and period in clk cycles.
- Results are exposed on the same simple register bus used by the generator (8-bit addr, 32-bit wdata/rdata, wen/ren).
- Used for closed-loop self-check of the PWM stage and as a general-purpose duty/period meter.

Parameters:
- CNT_W, 16, width of the high-time and period counters; MEAS packs {period, high} into 32 bits, so CNT_W must be 16.
- SYNC_STAGES, 2, number of flops in the pwm_in synchronizer (legal values 2..3).

Ports:
- clk  input  1  system clock, all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- addr  input  8  register byte address
- wdata  input  32  write data
- rdata  output  32  read data, registered
- wen  input  1  write strobe, sampled on posedge
- ren  input  1  read strobe, sampled on posedge
- pwm_in  input  1  measured pulse train, asynchronous to clk
- irq  output  1  level interrupt

Behaviour:
- Registers (decoded on addr; unmapped reads return 0, unmapped writes are ignored):
  - 0x00 CTRL (RW): bit0 enable, bit1 irq_en; all other bits read 0. Bit2 is clear: write-1 self-clearing pulse that zeroes MEAS and STATUS; it reads 0.
  - 0x04 STATUS: bit0 valid (RO, clears on MEAS read); bit1 timeout (W1C); bit2 level (RO, current synchronized input level).
  - 0x08 MEAS (RO): [31:16] period, [15:0] high.
- Reset: CTRL=0, STATUS=0, MEAS=0, rdata=0, irq=0, synchronizer flops=0, FSM=IDLE, counters=0.
- Bus timing:
  - Write takes effect on the posedge where wen=1.
  - When ren=1 at a posedge, rdata loads the addressed register on that edge. rdata holds its value while ren=0.
  - wen and ren asserted together: the write occurs and rdata returns the pre-write value.
- Input path: pwm_in passes through SYNC_STAGES flops to give s_in. An edge flop detects rise (s_in & ~s_prev) and fall (~s_in & s_prev).
  - Edge-detect latency from pwm_in to the rise/fall pulse is SYNC_STAGES+1 cycles.
  - Pulses shorter than 2 clk cycles are not guaranteed to be seen.
- FSM states:
  - IDLE: counters held at 0. Goes to ARM when enable=1.
  - ARM: waits for a rise, then goes to HIGH with hcnt=1, pcnt=1.
  - HIGH: hcnt++ and pcnt++ each cycle. On fall, latch h_lat=hcnt and go to LOW.
  - LOW: pcnt++ each cycle. On rise: MEAS<={pcnt,h_lat}, valid<=1, then go to HIGH with hcnt=1, pcnt=1.
  - The result is that high equals the cycles between rise and fall detection, and period equals the cycles between consecutive rises. A 30/100 input yields MEAS={100,30}.
- Timeout: if pcnt reaches 2^CNT_W-1 in HIGH or LOW, set timeout=1, leave MEAS unchanged, and go to ARM. A constant-level input therefore times out, and the next rise restarts measurement.
- enable cleared in any state: next cycle goes to IDLE. MEAS and STATUS are retained; a partial measurement is discarded.
- clear pulse: zeroes MEAS, valid and timeout, and forces the FSM to ARM if enabled, else IDLE.
- Simultaneous events: hardware set of valid or timeout wins over MEAS-read clear and over a W1C write in the same cycle.
  - A MEAS read coinciding with a capture returns the old MEAS; valid stays 1.
- irq = irq_en & (valid | timeout), registered (1 cycle after the flag sets).
- Counters never wrap; saturation is reported only via timeout.

Decomposition:
- Shared package pwm_bus_pkg holds:
  - address constants ADDR_CTRL=8'h00, ADDR_STATUS=8'h04, ADDR_MEAS=8'h08
  - CTRL/STATUS bit-index constants
  - FSM state encoding (IDLE, ARM, HIGH, LOW).
- One sub-module, pwm_edge_sync: SYNC_STAGES synchronizer plus rise/fall pulse generation, outputs s_in, rise, fall.
- Register file and FSM stay in pwm_capture.

Test Plan:
- Drive pwm_in from a 30-high/70-low cycle model with enable=1, run 3 periods, read MEAS -> 0x0064_001E, STATUS.valid=1, then valid=0 after the MEAS read.
- Write CTRL=0x3, drive 1-high/4-low input -> MEAS=0x0005_0001 and irq=1; read MEAS -> irq falls 1 cycle later.
- Hold pwm_in=1 for 70000 cycles -> STATUS=0x6 (timeout=1, level=1) and MEAS unchanged. Write STATUS=0x2 -> timeout=0.
- Clear enable mid-HIGH -> FSM goes to IDLE and MEAS keeps the previous value. Re-enable -> first capture only after two rises.
- Assert reset_n=0 asynchronously mid-LOW -> rdata, irq and all registers read 0 immediately after reset and on subsequent reads.
- Write CTRL bit2 after a valid capture -> MEAS=0, STATUS=0, CTRL reads back without bit2. Unmapped addr 0x0C reads 0.

Source files
------------

// File: rtl/pwm_bus_pkg.sv
// Shared register map, bit indices and capture FSM encoding for the PWM bus blocks.
package pwm_bus_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_MEAS   = 8'h08;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_CLR_BIT    = 2;

  localparam int unsigned STAT_VALID_BIT   = 0;
  localparam int unsigned STAT_TIMEOUT_BIT = 1;
  localparam int unsigned STAT_LEVEL_BIT   = 2;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ARM  = 2'd1,
    CAP_HIGH = 2'd2,
    CAP_LOW  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous pulse train and produces registered rise/fall pulses.
module pwm_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pwm_in,
  output logic s_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer chain, previous-level flop and registered edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a pulse train; results readable on the register bus.
module pwm_capture
  import pwm_bus_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        wen,
  input  logic        ren,
  input  logic        pwm_in,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s_in;
  logic rise;
  logic fall;

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hlat_q, hlat_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      meas_q, meas_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic        en_c;
  logic        ctrl_wr_c;
  logic        clr_c;
  logic        stat_w1c_c;
  logic        meas_rd_c;
  logic        capture_c;
  logic        tout_c;
  logic [31:0] rd_mux_c;
  logic        unused_wdata_c;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .pwm_in (pwm_in),
    .s_in   (s_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign en_c           = ctrl_q[CTRL_EN_BIT];
  assign ctrl_wr_c      = wen && (addr == ADDR_CTRL);
  assign clr_c          = ctrl_wr_c && wdata[CTRL_CLR_BIT];
  assign stat_w1c_c     = wen && (addr == ADDR_STATUS) && wdata[STAT_TIMEOUT_BIT];
  assign meas_rd_c      = ren && (addr == ADDR_MEAS);
  assign unused_wdata_c = ^wdata[31:3];

  // Capture FSM: next state, counters and capture/timeout events.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    pcnt_d    = pcnt_q;
    hlat_d    = hlat_q;
    capture_c = 1'b0;
    tout_c    = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        hcnt_d = '0;
        pcnt_d = '0;
        if (en_c) state_d = CAP_ARM;
      end
      CAP_ARM: begin
        hcnt_d = '0;
        pcnt_d = '0;
        if (rise) begin
          state_d = CAP_HIGH;
          hcnt_d  = CNT_W'(1);
          pcnt_d  = CNT_W'(1);
        end
      end
      CAP_HIGH: begin
        if (pcnt_q == CNT_MAX) begin
          tout_c  = 1'b1;
          state_d = CAP_ARM;
        end else begin
          hcnt_d = hcnt_q + CNT_W'(1);
          pcnt_d = pcnt_q + CNT_W'(1);
          if (fall) begin
            hlat_d  = hcnt_q;
            state_d = CAP_LOW;
          end
        end
      end
      CAP_LOW: begin
        if (pcnt_q == CNT_MAX) begin
          tout_c  = 1'b1;
          state_d = CAP_ARM;
        end else if (rise) begin
          capture_c = 1'b1;
          state_d   = CAP_HIGH;
          hcnt_d    = CNT_W'(1);
          pcnt_d    = CNT_W'(1);
        end else begin
          pcnt_d = pcnt_q + CNT_W'(1);
        end
      end
      default: state_d = CAP_IDLE;
    endcase
    // Disabling drops any partial measurement.
    if (!en_c) begin
      state_d   = CAP_IDLE;
      hcnt_d    = '0;
      pcnt_d    = '0;
      capture_c = 1'b0;
      tout_c    = 1'b0;
    end
    // Clear restarts from ARM using the enable value being written alongside it.
    if (clr_c) begin
      state_d   = wdata[CTRL_EN_BIT] ? CAP_ARM : CAP_IDLE;
      hcnt_d    = '0;
      pcnt_d    = '0;
      capture_c = 1'b0;
      tout_c    = 1'b0;
    end
  end

  // Read mux over the pre-write register values.
  always_comb begin
    rd_mux_c = '0;
    case (addr)
      ADDR_CTRL:   rd_mux_c = 32'(ctrl_q);
      ADDR_STATUS: begin
        rd_mux_c[STAT_VALID_BIT]   = valid_q;
        rd_mux_c[STAT_TIMEOUT_BIT] = timeout_q;
        rd_mux_c[STAT_LEVEL_BIT]   = s_in;
      end
      ADDR_MEAS:   rd_mux_c = meas_q;
      default:     rd_mux_c = '0;
    endcase
  end

  // Register file next state; hardware flag sets beat software clears, clear pulse beats all.
  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    meas_d    = meas_q;
    rdata_d   = rdata_q;
    irq_d     = ctrl_q[CTRL_IRQ_EN_BIT] & (valid_q | timeout_q);
    if (ctrl_wr_c) ctrl_d = {wdata[CTRL_IRQ_EN_BIT], wdata[CTRL_EN_BIT]};
    if (ren)       rdata_d = rd_mux_c;
    if (meas_rd_c) valid_d = 1'b0;
    if (stat_w1c_c) timeout_d = 1'b0;
    if (capture_c) begin
      valid_d = 1'b1;
      meas_d  = 32'({pcnt_q, hlat_q});
    end
    if (tout_c) timeout_d = 1'b1;
    if (clr_c) begin
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      meas_d    = '0;
    end
  end

  // State and register flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CAP_IDLE;
      hcnt_q    <= '0;
      pcnt_q    <= '0;
      hlat_q    <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      meas_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      pcnt_q    <= pcnt_d;
      hlat_q    <= hlat_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      meas_q    <= meas_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a cycle-based pulse generator.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic        pwm_in = 1'b0;
  logic        irq;

  int n_chk = 0;
  int n_bad = 0;

  int   cyc = 0;
  bit   gen_on = 1'b0;
  logic gen_lvl = 1'b0;
  int   gen_hi = 1;
  int   gen_lo = 1;
  int   gen_t0 = 0;

  pwm_capture #(
    .CNT_W      (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .wen    (wen),
    .ren    (ren),
    .pwm_in (pwm_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Pulse generator: periodic hi/lo pattern or a static level, updated off the clock edge.
  always begin
    @(posedge clk);
    #3;
    cyc = cyc + 1;
    if (gen_on) pwm_in = (((cyc - gen_t0) % (gen_hi + gen_lo)) < gen_hi);
    else        pwm_in = gen_lvl;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic bus_rw(input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rd);
    addr = a; wdata = wd; wen = 1'b1; ren = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
    rd = rdata;
  endtask

  task automatic gen_start(input int hi, input int lo);
    gen_hi = hi; gen_lo = lo; gen_t0 = cyc + 1; gen_on = 1'b1;
  endtask

  task automatic gen_hold(input logic lvl);
    gen_on = 1'b0; gen_lvl = lvl;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;

    // Reset values
    #2;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    #20 reset_n = 1'b1;
    wait_cyc(2);
    bus_read(8'h00, rd); check_eq("rst_ctrl", rd, 32'h0);
    bus_read(8'h04, rd); check_eq("rst_status", rd, 32'h0);
    bus_read(8'h08, rd); check_eq("rst_meas", rd, 32'h0);

    // 30/70 pattern, three periods
    bus_write(8'h00, 32'h1);
    gen_start(30, 70);
    wait_cyc(350);
    gen_hold(1'b0);
    wait_cyc(10);
    bus_read(8'h04, rd); check_eq("p30_status_valid", rd, 32'h1);
    bus_read(8'h08, rd); check_eq("p30_meas", rd, 32'h0064_001E);
    bus_read(8'h04, rd); check_eq("p30_status_after_rd", rd, 32'h0);

    // 1/4 pattern with interrupts enabled
    bus_write(8'h00, 32'h3);
    gen_start(1, 4);
    wait_cyc(60);
    gen_hold(1'b0);
    wait_cyc(10);
    check_eq("p1_irq_set", 32'(irq), 32'h1);
    bus_read(8'h08, rd); check_eq("p1_meas", rd, 32'h0005_0001);
    check_eq("p1_irq_hold", 32'(irq), 32'h1);
    wait_cyc(1);
    check_eq("p1_irq_fall", 32'(irq), 32'h0);

    // Constant high input saturates the period counter
    bus_write(8'h00, 32'h0);
    bus_write(8'h00, 32'h3);
    gen_hold(1'b1);
    wait_cyc(70000);
    bus_read(8'h04, rd); check_eq("tout_status", rd, 32'h6);
    check_eq("tout_irq", 32'(irq), 32'h1);
    bus_read(8'h08, rd); check_eq("tout_meas_kept", rd, 32'h0005_0001);
    bus_write(8'h04, 32'h2);
    bus_read(8'h04, rd); check_eq("tout_w1c", rd, 32'h4);
    wait_cyc(1);
    check_eq("tout_irq_clr", 32'(irq), 32'h0);

    // Disable mid-HIGH keeps MEAS; re-enable needs two rises
    gen_hold(1'b0);
    bus_write(8'h00, 32'h1);
    wait_cyc(5);
    gen_start(20, 50);
    wait_cyc(80);
    @(posedge pwm_in);
    wait_cyc(10);
    bus_write(8'h00, 32'h0);
    gen_hold(1'b0);
    wait_cyc(10);
    bus_read(8'h04, rd); check_eq("dis_status_valid", rd & 32'h3, 32'h1);
    bus_read(8'h08, rd); check_eq("dis_meas_kept", rd, 32'h0046_0014);
    bus_write(8'h00, 32'h1);
    wait_cyc(5);
    gen_start(10, 30);
    wait_cyc(25);
    bus_read(8'h08, rd); check_eq("reen_one_rise", rd, 32'h0046_0014);
    wait_cyc(30);
    bus_read(8'h08, rd); check_eq("reen_two_rises", rd, 32'h0028_000A);

    // Asynchronous reset while in LOW
    bus_write(8'h00, 32'h3);
    wait_cyc(45);
    @(negedge pwm_in);
    repeat (5) @(posedge clk);
    #2;
    check_eq("pre_rst_irq", 32'(irq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_rdata", rdata, 32'h0);
    check_eq("arst_irq", 32'(irq), 32'h0);
    gen_hold(1'b0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    wait_cyc(1);
    bus_read(8'h00, rd); check_eq("arst_ctrl", rd, 32'h0);
    bus_read(8'h04, rd); check_eq("arst_status", rd, 32'h0);
    bus_read(8'h08, rd); check_eq("arst_meas", rd, 32'h0);
    check_eq("arst_irq_after", 32'(irq), 32'h0);

    // Clear pulse, unmapped address, simultaneous read and write
    bus_write(8'h00, 32'h1);
    gen_start(10, 30);
    wait_cyc(100);
    gen_hold(1'b0);
    wait_cyc(10);
    bus_read(8'h04, rd); check_eq("clr_pre_valid", rd, 32'h1);
    bus_write(8'h00, 32'h5);
    bus_read(8'h00, rd); check_eq("clr_ctrl", rd, 32'h1);
    bus_read(8'h08, rd); check_eq("clr_meas", rd, 32'h0);
    bus_read(8'h04, rd); check_eq("clr_status", rd, 32'h0);
    bus_read(8'h0C, rd); check_eq("unmapped_rd", rd, 32'h0);
    bus_write(8'h0C, 32'hFFFF_FFFF);
    bus_read(8'h00, rd); check_eq("unmapped_wr", rd, 32'h1);
    bus_rw(8'h00, 32'h3, rd); check_eq("rw_old", rd, 32'h1);
    bus_read(8'h00, rd); check_eq("rw_new", rd, 32'h3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
